// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: reset fetch address, bubble instruction, fetch FSM encoding
// and the {instruction, pc_plus_four} entry carried from fetch to decode.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus_four;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {instruction, pc_plus_four}; flush empties it and wins over push/pop.
module fetch_queue
   import fetch_stage_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   assign push_ok = push && (count != 2'd2);
   assign pop_ok  = pop && (count != 2'd0);
   assign head    = slot[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= !wr_ptr;
         if (pop_ok)  rd_ptr <= !rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   // Storage needs no reset; count gates every read of it.
   always_ff @(posedge clock) begin
      if (push_ok && !flush) slot[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one-outstanding instruction memory requester feeding a 2-entry queue to decode.
//
//   state | meaning
//   IDLE  | queue has no room for another fetch, no request outstanding
//   REQ   | presenting imem_addr = fetch PC, waiting for imem_ready
//   WAIT  | one request accepted, waiting for imem_rvalid
//   DROP  | accepted request belongs to a redirected-away path; discard its response
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
)(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          stall_F,
   input  logic          pc_src,
   input  logic [31:0]   jump_address,
   fetch_stage_if.master imem,
   output logic [31:0]   instruction,
   output logic [31:0]   pc_plus_four,
   output logic          instr_valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         req_q;
   fetch_entry_t head;
   fetch_entry_t push_data;
   logic [1:0]   count;
   logic         pop;
   logic         redirect;
   logic         accept;
   logic         push;
   logic         room_now;
   logic         room_after;
   logic         issue_in_wait;

   assign instr_valid  = (count != 2'd0);
   assign instruction  = instr_valid ? head.instr : NOP_WORD;
   assign pc_plus_four = instr_valid ? head.pc_plus_four : 32'd0;

   assign pop        = instr_valid && !stall_F;
   assign redirect   = pop && pc_src;
   assign room_now   = (count != 2'd2) || pop;
   assign room_after = (count == 2'd0) || ((count == 2'd1) && pop);

   // Re-issue in the same cycle a response lands so zero-wait memory sustains one fetch per cycle.
   assign issue_in_wait = (state == WAIT) && imem.imem_rvalid && room_after && !redirect;

   assign imem.imem_req  = req_q || issue_in_wait;
   assign imem.imem_addr = pc;
   assign accept         = imem.imem_req && imem.imem_ready;

   // While WAIT is outstanding the fetch PC already equals the request address + 4.
   assign push = (state == WAIT) && imem.imem_rvalid && !redirect;
   assign push_data.instr        = imem.imem_rdata;
   assign push_data.pc_plus_four = pc;

   fetch_queue u_queue (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= REQ;
         pc    <= RESET_PC;
         req_q <= 1'b0;
      end else if (redirect) begin
         pc <= jump_address;
         if ((state == REQ && accept) || (state == WAIT && !imem.imem_rvalid) ||
             (state == DROP && !imem.imem_rvalid)) begin
            state <= DROP;
            req_q <= 1'b0;
         end else begin
            state <= REQ;
            req_q <= 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (room_now) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            REQ: begin
               if (accept) begin
                  state <= WAIT;
                  req_q <= 1'b0;
                  pc    <= pc + 32'd4;
               end else begin
                  req_q <= 1'b1;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  if (accept) begin
                     pc <= pc + 32'd4;
                  end else if (room_after) begin
                     state <= REQ;
                     req_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DROP: begin
               if (imem.imem_rvalid) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
